// File: rtl/bnn_vote_filter_if.sv
// Bundle between the BNN classifier side and the vote filter.
// Valid/ready: in_valid is a one-cycle pulse with no backpressure; vote_valid is a one-cycle publish pulse.
interface bnn_vote_filter_if;
   logic       in_valid;
   logic [2:0] in_class;
   logic       clear;
   logic       vote_valid;
   logic       vote_class;
   logic [3:0] vote_margin;
   logic       stable;
   logic       err;
   logic       dbg_state;
   logic [3:0] dbg_cnt;
   logic [2:0] dbg_streak;

   modport master (
      output in_valid, in_class, clear,
      input  vote_valid, vote_class, vote_margin, stable, err,
      input  dbg_state, dbg_cnt, dbg_streak
   );

   modport slave (
      input  in_valid, in_class, clear,
      output vote_valid, vote_class, vote_margin, stable, err,
      output dbg_state, dbg_cnt, dbg_streak
   );
endinterface

// File: rtl/bnn_vote_filter.sv
// Majority-vote debouncer for BNN class results: windows of WINDOW legal samples,
// publishes class/margin, and flags stability after STABLE_N agreeing windows.
module bnn_vote_filter #(
   parameter int WINDOW   = 8,
   parameter int STABLE_N = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   bnn_vote_filter_if.slave bus
);

   localparam logic [3:0] WIN = 4'(WINDOW);
   localparam logic [2:0] STB = 3'(STABLE_N);

   typedef enum logic {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;

   state_t     state_q;
   logic [3:0] cnt_q;
   logic [3:0] ones_q;
   logic [2:0] streak_q;
   logic       published_q;
   logic       vote_valid_q;
   logic       vote_class_q;
   logic [3:0] vote_margin_q;
   logic       stable_q;
   logic       err_q;

   logic       legal;
   logic [4:0] twice;
   logic [4:0] diff;
   logic       vote_class_d;
   logic [3:0] vote_margin_d;
   logic [2:0] streak_d;

   assign legal = (bus.in_class[2:1] == 2'b00);

   // Vote computed from the latched window while in PUBLISH.
   always_comb begin
      twice         = {ones_q, 1'b0};
      diff          = (twice >= {1'b0, WIN}) ? (twice - {1'b0, WIN}) : ({1'b0, WIN} - twice);
      vote_margin_d = (diff > 5'd15) ? 4'hF : diff[3:0];
      vote_class_d  = vote_class_q;
      if (twice > {1'b0, WIN}) begin
         vote_class_d = 1'b1;
      end else if (twice < {1'b0, WIN}) begin
         vote_class_d = 1'b0;
      end
      streak_d = 3'd1;
      if (published_q && (vote_class_d == vote_class_q)) begin
         streak_d = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= COLLECT;
         cnt_q         <= 4'd0;
         ones_q        <= 4'd0;
         streak_q      <= 3'd0;
         published_q   <= 1'b0;
         vote_valid_q  <= 1'b0;
         vote_class_q  <= 1'b0;
         vote_margin_q <= 4'd0;
         stable_q      <= 1'b0;
         err_q         <= 1'b0;
      end else if (!ena) begin
         vote_valid_q <= 1'b0;
      end else begin
         vote_valid_q <= 1'b0;
         if (bus.clear) begin
            state_q     <= COLLECT;
            cnt_q       <= 4'd0;
            ones_q      <= 4'd0;
            streak_q    <= 3'd0;
            published_q <= 1'b0;
            stable_q    <= 1'b0;
            err_q       <= 1'b0;
         end else begin
            case (state_q)
               COLLECT: begin
                  if (bus.in_valid) begin
                     if (legal) begin
                        cnt_q  <= cnt_q + 4'd1;
                        ones_q <= ones_q + {3'b000, bus.in_class[0]};
                        if (cnt_q + 4'd1 == WIN) begin
                           state_q <= PUBLISH;
                        end
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               PUBLISH: begin
                  state_q       <= COLLECT;
                  vote_valid_q  <= 1'b1;
                  vote_class_q  <= vote_class_d;
                  vote_margin_q <= vote_margin_d;
                  streak_q      <= streak_d;
                  stable_q      <= (streak_d >= STB);
                  published_q   <= 1'b1;
                  cnt_q         <= 4'd0;
                  ones_q        <= 4'd0;
                  // A sample arriving now opens the next window rather than being lost.
                  if (bus.in_valid) begin
                     if (legal) begin
                        cnt_q  <= 4'd1;
                        ones_q <= {3'b000, bus.in_class[0]};
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               default: state_q <= COLLECT;
            endcase
         end
      end
   end

   assign bus.vote_valid  = vote_valid_q;
   assign bus.vote_class  = vote_class_q;
   assign bus.vote_margin = vote_margin_q;
   assign bus.stable      = stable_q;
   assign bus.err         = err_q;
   assign bus.dbg_state   = state_q;
   assign bus.dbg_cnt     = cnt_q;
   assign bus.dbg_streak  = streak_q;

endmodule

// File: tb/tb_bnn_vote_filter.sv
// Directed bench for bnn_vote_filter: table of vote windows plus hand sequences
// for error, clear, publish collision, enable and async reset.
module tb_bnn_vote_filter;

   logic clk;
   logic rst_n;
   logic ena;
   int   n_checks;
   int   n_errors;

   bnn_vote_filter_if bus ();

   bnn_vote_filter #(.WINDOW(8), .STABLE_N(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mask;
      int         gap;
      logic       exp_class;
      logic [3:0] exp_margin;
      logic [2:0] exp_streak;
      logic       exp_stable;
   } win_t;

   win_t tbl[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [2:0] cls, input int gap);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_class = cls;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_class = 3'd0;
      repeat (gap) @(negedge clk);
   endtask

   // Sends bits 0..n-1 of mask as classes; the last one with no trailing gap.
   task automatic send_n(input logic [7:0] mask, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         pulse({2'b00, mask[i]}, (i == n - 1) ? 0 : gap);
      end
   endtask

   // Called right after the completing pulse: vote_valid must appear exactly one cycle later.
   task automatic expect_vote(input string tag, input logic c, input logic [3:0] m,
                              input logic [2:0] s, input logic st);
      chk({tag, "_vv_early"}, bus.vote_valid, 1'b0);
      chk({tag, "_state_pub"}, bus.dbg_state, 1'b1);
      @(negedge clk);
      chk({tag, "_vv"}, bus.vote_valid, 1'b1);
      chk({tag, "_class"}, bus.vote_class, c);
      chk({tag, "_margin"}, bus.vote_margin, m);
      chk({tag, "_streak"}, bus.dbg_streak, s);
      chk({tag, "_stable"}, bus.stable, st);
      @(negedge clk);
      chk({tag, "_vv_end"}, bus.vote_valid, 1'b0);
   endtask

   initial begin
      int vv_seen;
      n_checks     = 0;
      n_errors     = 0;
      rst_n        = 1'b0;
      ena          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_class = 3'd0;
      bus.clear    = 1'b0;

      tbl[0]  = '{8'hFF, 5, 1'b1, 4'd8, 3'd1, 1'b0};
      tbl[1]  = '{8'hF0, 1, 1'b1, 4'd0, 3'd2, 1'b0};
      tbl[2]  = '{8'hC0, 0, 1'b0, 4'd4, 3'd1, 1'b0};
      tbl[3]  = '{8'hC0, 2, 1'b0, 4'd4, 3'd2, 1'b0};
      tbl[4]  = '{8'hC0, 0, 1'b0, 4'd4, 3'd3, 1'b1};
      tbl[5]  = '{8'hFF, 1, 1'b1, 4'd8, 3'd1, 1'b0};
      tbl[6]  = '{8'hAA, 0, 1'b1, 4'd0, 3'd2, 1'b0};
      tbl[7]  = '{8'h01, 3, 1'b0, 4'd6, 3'd1, 1'b0};
      tbl[8]  = '{8'h00, 0, 1'b0, 4'd8, 3'd2, 1'b0};
      tbl[9]  = '{8'h00, 0, 1'b0, 4'd8, 3'd3, 1'b1};
      tbl[10] = '{8'h00, 0, 1'b0, 4'd8, 3'd4, 1'b1};
      tbl[11] = '{8'h00, 0, 1'b0, 4'd8, 3'd5, 1'b1};
      tbl[12] = '{8'h00, 0, 1'b0, 4'd8, 3'd6, 1'b1};
      tbl[13] = '{8'h00, 0, 1'b0, 4'd8, 3'd7, 1'b1};
      tbl[14] = '{8'h00, 1, 1'b0, 4'd8, 3'd7, 1'b1};

      // Reset state and idle
      repeat (3) @(negedge clk);
      chk("rst_vv", bus.vote_valid, 1'b0);
      chk("rst_class", bus.vote_class, 1'b0);
      chk("rst_margin", bus.vote_margin, 4'd0);
      chk("rst_stable", bus.stable, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_cnt", bus.dbg_cnt, 4'd0);
      rst_n = 1'b1;
      vv_seen = 0;
      repeat (20) begin
         @(negedge clk);
         vv_seen += int'(bus.vote_valid);
      end
      chk("idle_vv", vv_seen, 0);
      chk("idle_class", bus.vote_class, 1'b0);
      chk("idle_margin", bus.vote_margin, 4'd0);
      chk("idle_stable", bus.stable, 1'b0);
      chk("idle_err", bus.err, 1'b0);

      // Window table
      for (int t = 0; t < 15; t++) begin
         send_n(tbl[t].mask, 8, tbl[t].gap);
         expect_vote($sformatf("win%0d", t), tbl[t].exp_class, tbl[t].exp_margin,
                     tbl[t].exp_streak, tbl[t].exp_stable);
      end

      // Illegal class mid-window, then clear
      send_n(8'hFF, 3, 1);
      pulse(3'd3, 0);
      chk("ill_err", bus.err, 1'b1);
      chk("ill_cnt", bus.dbg_cnt, 4'd3);
      send_n(8'hFF, 5, 0);
      expect_vote("ill_win", 1'b1, 4'd8, 3'd1, 1'b0);
      chk("ill_err_sticky", bus.err, 1'b1);
      send_n(8'h00, 2, 0);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clr_err", bus.err, 1'b0);
      chk("clr_cnt", bus.dbg_cnt, 4'd0);
      chk("clr_streak", bus.dbg_streak, 3'd0);
      chk("clr_stable", bus.stable, 1'b0);
      chk("clr_vv", bus.vote_valid, 1'b0);
      chk("clr_class_hold", bus.vote_class, 1'b1);
      chk("clr_margin_hold", bus.vote_margin, 4'd8);

      // Sample arriving during PUBLISH opens the next window
      send_n(8'h00, 8, 0);
      bus.in_valid = 1'b1;
      bus.in_class = 3'd1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_class = 3'd0;
      chk("col_vv", bus.vote_valid, 1'b1);
      chk("col_class", bus.vote_class, 1'b0);
      chk("col_margin", bus.vote_margin, 4'd8);
      chk("col_streak", bus.dbg_streak, 3'd1);
      chk("col_cnt", bus.dbg_cnt, 4'd1);
      send_n(8'hFF, 7, 1);
      expect_vote("col_win", 1'b1, 4'd8, 3'd1, 1'b0);

      // clear coincident with in_valid drops the sample
      send_n(8'hFF, 2, 0);
      @(negedge clk);
      bus.clear    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_class = 3'd1;
      @(negedge clk);
      bus.clear    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_class = 3'd0;
      chk("clrcol_cnt", bus.dbg_cnt, 4'd0);

      // ena low: samples ignored
      ena = 1'b0;
      pulse(3'd1, 0);
      pulse(3'd3, 0);
      chk("ena_cnt", bus.dbg_cnt, 4'd0);
      chk("ena_err", bus.err, 1'b0);
      ena = 1'b1;

      // Async reset mid-window
      send_n(8'hFF, 3, 0);
      chk("pre_rst_cnt", bus.dbg_cnt, 4'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt", bus.dbg_cnt, 4'd0);
      chk("arst_class", bus.vote_class, 1'b0);
      chk("arst_margin", bus.vote_margin, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_n(8'hFF, 7, 0);
      vv_seen = 0;
      repeat (3) begin
         @(negedge clk);
         vv_seen += int'(bus.vote_valid);
      end
      chk("arst_no_vote", vv_seen, 0);
      chk("arst_cnt7", bus.dbg_cnt, 4'd7);
      pulse(3'd1, 0);
      expect_vote("arst_win", 1'b1, 4'd8, 3'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
